// File: rtl/matrix_scan_pkg.sv
// matrix_scan shared definitions.
// Defaults, width helper and row-phase offsets.
package matrix_scan_pkg;

  localparam int GS_DEF = 8;

  // Cycle within a row that is always blanked.
  localparam int BLANK_CYC = 0;
  // Tick request lands this many cycles before the row ends.
  localparam int REQ_BACK = 3;
  // Frame capture happens on the last cycle of the row.
  localparam int CAP_BACK = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/matrix_scan_timer.sv
// matrix_scan cascaded cycle/row/frame counters.
// Emits tick request, capture and frame-start strobes.
module matrix_scan_timer
  import matrix_scan_pkg::*;
#(
  parameter int GS              = GS_DEF,
  parameter int ROW_CYCLES      = 256,
  parameter int FRAMES_PER_TICK = 4,
  localparam int CW = clog2(ROW_CYCLES),
  localparam int RW = clog2(GS),
  localparam int FW = clog2(FRAMES_PER_TICK)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  output logic          req_pulse,
  output logic          cap_pulse,
  output logic          frame_start,
  output logic          blank,
  output logic [RW-1:0] row_cnt
);

  localparam int REQ_CYC = ROW_CYCLES - REQ_BACK;
  localparam int CAP_CYC = ROW_CYCLES - CAP_BACK;

  logic [CW-1:0] cyc_cnt;
  logic [FW-1:0] frame_cnt;
  logic          last_cyc;
  logic          last_row;
  logic          last_frame;
  logic          tick_row;

  assign last_cyc   = cyc_cnt == CW'(ROW_CYCLES - 1);
  assign last_row   = row_cnt == RW'(GS - 1);
  assign last_frame = frame_cnt == FW'(FRAMES_PER_TICK - 1);
  assign tick_row   = last_row && last_frame;

  // Decoded one cycle early so the registered e_act_o sits on REQ_CYC.
  assign req_pulse   = tick_row && (cyc_cnt == CW'(REQ_CYC - 1));
  assign cap_pulse   = tick_row && (cyc_cnt == CW'(CAP_CYC));
  assign blank       = cyc_cnt == CW'(BLANK_CYC);
  assign frame_start = blank && (row_cnt == '0);

  // Cascaded wrap-around counters: cycle -> row -> frame.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cyc_cnt   <= '0;
      row_cnt   <= '0;
      frame_cnt <= '0;
    end else if (last_cyc) begin
      cyc_cnt <= '0;
      if (last_row) begin
        row_cnt   <= '0;
        frame_cnt <= last_frame ? '0 : frame_cnt + 1'b1;
      end else begin
        row_cnt <= row_cnt + 1'b1;
      end
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_scan.sv
// matrix_scan: paces game logic and row-scans an LED matrix.
// Shadow frame is swapped only at tick boundaries.
module matrix_scan
  import matrix_scan_pkg::*;
#(
  parameter int GS              = GS_DEF,
  parameter int ROW_CYCLES      = 256,
  parameter int FRAMES_PER_TICK = 4
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic [GS*GS-1:0] matrix_i,
  input  logic            d_act_i,
  output logic            e_act_o,
  output logic [GS-1:0]   row_o,
  output logic [GS-1:0]   col_o,
  output logic            frame_o
);

  localparam int RW = clog2(GS);

  logic             req_pulse;
  logic             cap_pulse;
  logic             frame_start;
  logic             blank;
  logic [RW-1:0]    row_cnt;
  logic [GS*GS-1:0] shadow;

  matrix_scan_timer #(
    .GS              (GS),
    .ROW_CYCLES      (ROW_CYCLES),
    .FRAMES_PER_TICK (FRAMES_PER_TICK)
  ) u_scan_timer (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .req_pulse   (req_pulse),
    .cap_pulse   (cap_pulse),
    .frame_start (frame_start),
    .blank       (blank),
    .row_cnt     (row_cnt)
  );

  // Capture the returned frame only at the tick capture slot.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      shadow <= '0;
    end else if (cap_pulse && d_act_i) begin
      shadow <= matrix_i;
    end
  end

  // Registered scan and handshake outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      row_o   <= '0;
      col_o   <= '1;
      frame_o <= 1'b0;
      e_act_o <= 1'b0;
    end else begin
      frame_o <= frame_start;
      e_act_o <= req_pulse;
      if (blank) begin
        row_o <= '0;
        col_o <= '1;
      end else begin
        row_o <= GS'(1) << row_cnt;
        col_o <= ~shadow[GS*row_cnt +: GS];
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan.sv
// tb_matrix_scan: directed + random bench for matrix_scan.
// Expected outputs derived from cycle arithmetic.
module tb_matrix_scan;

  localparam int GS    = 8;
  localparam int RC    = 8;
  localparam int FPT   = 2;
  localparam int FRAME = GS * RC;
  localparam int TICK  = FRAME * FPT;

  logic             clk_i;
  logic             reset_ni;
  logic [GS*GS-1:0] matrix_i;
  logic             d_act_i;
  logic             e_act_o;
  logic [GS-1:0]    row_o;
  logic [GS-1:0]    col_o;
  logic             frame_o;

  matrix_scan #(
    .GS              (GS),
    .ROW_CYCLES      (RC),
    .FRAMES_PER_TICK (FPT)
  ) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .matrix_i (matrix_i),
    .d_act_i  (d_act_i),
    .e_act_o  (e_act_o),
    .row_o    (row_o),
    .col_o    (col_o),
    .frame_o  (frame_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks;
  int fails;
  int n;
  int pulses;
  logic [GS*GS-1:0] sh_prev;
  logic [GS*GS-1:0] sh_cur;
  logic [GS*GS-1:0] sh_next;
  logic [GS*GS-1:0] diag;
  logic [GS*GS-1:0] ones;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s n=%0d got %h want %h", tag, n, obs, exp_v);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_row"}, 64'(row_o), 64'h0);
    chk({tag, "_col"}, 64'(col_o), 64'hFF);
    chk({tag, "_eact"}, 64'(e_act_o), 64'h0);
    chk({tag, "_frame"}, 64'(frame_o), 64'h0);
  endtask

  // n = counter position of the DUT; outputs show position n-1.
  task automatic check_outputs();
    int m, cyc, row;
    logic [GS-1:0] er, ec;
    logic ef, ee;
    ee = (n % TICK) == (TICK - 3);
    if (n == 0) begin
      er = '0;
      ec = '1;
      ef = 1'b0;
    end else begin
      m   = n - 1;
      cyc = m % RC;
      row = (m / RC) % GS;
      ef  = (m % FRAME) == 0;
      if (cyc == 0) begin
        er = '0;
        ec = '1;
      end else begin
        er = GS'(1) << row;
        ec = ~sh_prev[GS*row +: GS];
      end
    end
    chk("row", 64'(row_o), 64'(er));
    chk("col", 64'(col_o), 64'(ec));
    chk("frame", 64'(frame_o), 64'(ef));
    chk("eact", 64'(e_act_o), 64'(ee));
  endtask

  // One clock: check, model the capture, advance.
  task automatic cycle();
    check_outputs();
    if (((n % TICK) == (TICK - 1)) && d_act_i) sh_next = matrix_i;
    else sh_next = sh_cur;
    if (e_act_o) pulses++;
    @(posedge clk_i);
    n++;
    sh_prev = sh_cur;
    sh_cur  = sh_next;
    @(negedge clk_i);
  endtask

  task automatic do_reset(input string tag);
    reset_ni = 1'b0;
    #1;
    chk_reset_vals(tag);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    n       = 0;
    sh_prev = '0;
    sh_cur  = '0;
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    pulses   = 0;
    n        = 0;
    reset_ni = 1'b0;
    matrix_i = '0;
    d_act_i  = 1'b0;
    ones     = '1;
    diag     = '0;
    for (int r = 0; r < GS; r++) diag[9*r] = 1'b1;
    sh_prev = '0;
    sh_cur  = '0;
    @(negedge clk_i);
    do_reset("init");

    // Blank scan, then diagonal captured at the first tick.
    matrix_i = diag;
    d_act_i  = 1'b1;
    repeat (TICK) cycle();

    // Mid-frame change to all ones; takes effect at next capture.
    for (int i = 0; i < TICK; i++) begin
      if (i == 22) matrix_i = ones;
      cycle();
    end

    // Skipped capture: shadow holds, pulse still on schedule.
    d_act_i = 1'b0;
    for (int i = 0; i < TICK; i++) begin
      matrix_i = {$urandom, $urandom};
      cycle();
    end

    // Ten random ticks.
    pulses = 0;
    for (int t = 0; t < 10; t++) begin
      d_act_i = $urandom_range(0, 3) != 0;
      for (int i = 0; i < TICK; i++) begin
        matrix_i = {$urandom, $urandom};
        cycle();
      end
    end
    chk("pulse_count", 64'(pulses), 64'd10);

    // Reset while row 5 is displayed.
    for (int i = 0; i < FRAME; i++) begin
      if ((((n - 1) % FRAME) / RC == 5) && (((n - 1) % RC) == 3)) break;
      cycle();
    end
    chk("row5_live", 64'(row_o), 64'h20);
    do_reset("midrst");

    // Cleared shadow, then random captures again.
    d_act_i = 1'b0;
    repeat (TICK) cycle();
    d_act_i = 1'b1;
    for (int i = 0; i < TICK + FRAME; i++) begin
      matrix_i = {$urandom, $urandom};
      cycle();
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
